// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit for the multicycle CPU datapath. A one-cycle
// start command launches a signed or unsigned multiply (shift-add) or divide
// (restoring shift-subtract). One iteration runs per cycle, followed by one
// sign-fix cycle. The HI/LO result registers live here.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_mult, start_div one-cycle commands, sampled only while idle
//   is_signed             two's-complement operation when 1
//   a, b                  multiplicand/dividend and multiplier/divisor
//   hi, lo                product halves, or remainder/quotient
//   busy                  operation in progress
//   done                  one-cycle completion pulse
//   div_zero              one-cycle pulse with done when dividing by zero
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MRUN, DRUN, FIX} state_t;

  state_t state, state_next;

  // acc holds the running {upper, lower} product while multiplying, and
  // {remainder, dividend/quotient} while dividing.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand_b;
  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_lo;
  logic               neg_hi;

  logic accept_mult, accept_div, zero_div, last_step;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH+1:0]   div_trial;
  logic               div_borrow;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // start_mult wins over start_div; a zero divisor is answered straight from IDLE.
  assign accept_mult = (state == IDLE) && start_mult;
  assign accept_div  = (state == IDLE) && !start_mult && start_div && (b != '0);
  assign zero_div    = (state == IDLE) && !start_mult && start_div && (b == '0);
  assign last_step   = (count == CW'(WIDTH - 1));
  assign busy        = (state != IDLE);

  // Signed operands are reduced to magnitudes at capture; the most negative
  // value negates to itself, which is the correct unsigned magnitude.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, keeping the carry, then shift right by one.
  assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
  assign mult_next = {mult_sum, acc[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and try a
  // subtract. On borrow the remainder is below the divisor, so its top bit is
  // zero and dropping it is safe.
  assign div_trial  = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand_b};
  assign div_borrow = div_trial[WIDTH+1];
  assign div_next   = div_borrow ? {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix applied in the FIX cycle.
  assign prod_fixed = neg_lo ? -acc : acc;
  assign quot_fixed = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fixed  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: run WIDTH iterations, then one fix cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_mult)     state_next = MRUN;
        else if (accept_div) state_next = DRUN;
      end
      MRUN:    if (last_step) state_next = FIX;
      DRUN:    if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counter and result registers. hi/lo only change in FIX, so the
  // previous result stays visible for the whole operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      operand_b <= '0;
      count     <= '0;
      op_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_mult || accept_div) begin
            acc       <= {{WIDTH{1'b0}}, a_mag};
            operand_b <= b_mag;
            count     <= '0;
            op_div    <= accept_div;
            neg_lo    <= a_neg ^ b_neg;
            neg_hi    <= a_neg;
          end else if (zero_div) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end
        end
        MRUN: begin
          acc   <= mult_next;
          count <= count + 1'b1;
        end
        DRUN: begin
          acc   <= div_next;
          count <= count + 1'b1;
        end
        FIX: begin
          if (op_div) begin
            hi <= rem_fixed;
            lo <= quot_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
          done  <= 1'b1;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. A 32-bit and an 8-bit instance are
// driven with directed corner cases and random operations; expected results
// come from a plain-arithmetic model of the multiply/divide rules.
module tb_mult_div_unit;

  logic clk;
  logic reset;

  logic        start_mult, start_div, is_signed;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;

  logic        start_mult8, start_div8, is_signed8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, div_zero8;

  int compared   = 0;
  int mismatched = 0;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .is_signed(is_signed), .a(a), .b(b), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_mult(start_mult8), .start_div(start_div8),
    .is_signed(is_signed8), .a(a8), .b(b8), .hi(hi8), .lo(lo8),
    .busy(busy8), .done(done8), .div_zero(div_zero8)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: ordinary integer arithmetic on sign- or zero-extended
  // operands. SystemVerilog division already truncates toward zero and gives
  // the remainder the dividend's sign.
  task automatic refModel(input int w, input bit is_div, input bit sgn,
                          input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] eh, output logic [31:0] el);
    longint mask, ua, ub, sa, sb, x, y, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    sa = (ua ^ (longint'(1) << (w - 1))) - (longint'(1) << (w - 1));
    sb = (ub ^ (longint'(1) << (w - 1))) - (longint'(1) << (w - 1));
    x = sgn ? sa : ua;
    y = sgn ? sb : ub;
    if (!is_div) begin
      p  = x * y;
      eh = 32'((p >> w) & mask);
      el = 32'(p & mask);
    end else begin
      q  = x / y;
      r  = x % y;
      eh = 32'(r & mask);
      el = 32'(q & mask);
    end
  endtask

  function automatic logic [31:0] curHi(input int w);
    return (w == 8) ? {24'b0, hi8} : hi;
  endfunction
  function automatic logic [31:0] curLo(input int w);
    return (w == 8) ? {24'b0, lo8} : lo;
  endfunction
  function automatic logic curBusy(input int w);
    return (w == 8) ? busy8 : busy;
  endfunction
  function automatic logic curDone(input int w);
    return (w == 8) ? done8 : done;
  endfunction
  function automatic logic curDivZero(input int w);
    return (w == 8) ? div_zero8 : div_zero;
  endfunction

  // Drives the command inputs of the selected instance.
  task automatic applyStimulus(input int w, input bit sm, input bit sd, input bit sg,
                               input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      start_mult8 = sm; start_div8 = sd; is_signed8 = sg; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start_mult = sm; start_div = sd; is_signed = sg; a = av; b = bv;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Runs one operation starting from the current cycle (called #1 after an
  // edge) and checks latency, busy, held results and the final hi/lo.
  // 'both' raises both starts; 'inject' pulses start_div mid-operation.
  task automatic doOp(input int w, input bit is_div, input bit sgn,
                      input logic [31:0] av, input logic [31:0] bv,
                      input bit both, input bit inject, input string tag);
    logic [31:0] exp_hi, exp_lo, prev_hi, prev_lo;
    int cycles;
    bit busy_ok, hold_ok;
    refModel(w, is_div, sgn, av, bv, exp_hi, exp_lo);
    prev_hi = curHi(w);
    prev_lo = curLo(w);
    applyStimulus(w, !is_div || both, is_div || both, sgn, av, bv);
    @(posedge clk); #1;
    applyStimulus(w, 1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
    cycles  = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!curDone(w) && cycles < 200) begin
      if (!curBusy(w)) busy_ok = 1'b0;
      if (curHi(w) !== prev_hi || curLo(w) !== prev_lo) hold_ok = 1'b0;
      if (inject && cycles == 4)
        applyStimulus(w, 1'b0, 1'b1, 1'($urandom), $urandom, $urandom | 32'h1);
      else
        applyStimulus(w, 1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(w + 1));
    checkOutput({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, "_hold"}, 64'(hold_ok), 64'd1);
    checkOutput({tag, "_busy_after"}, 64'(curBusy(w)), 64'd0);
    checkOutput({tag, "_divzero"}, 64'(curDivZero(w)), 64'd0);
    checkOutput({tag, "_hi"}, 64'(curHi(w)), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(curLo(w)), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomOps(input int w, input int n);
    logic [31:0] av, bv;
    bit is_div, sgn;
    for (int i = 0; i < n; i++) begin
      is_div = 1'($urandom);
      sgn    = 1'($urandom);
      av     = pickOperand();
      bv     = pickOperand();
      if (is_div && ((w == 8) ? (bv[7:0] == 8'h00) : (bv == 32'h0))) bv = 32'h3;
      doOp(w, is_div, sgn, av, bv, 1'b0, 1'b0, $sformatf("rand%0d_%0d", w, i));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
  endtask

  int  waited;
  bit  saw_done;

  initial begin
    reset = 1'b1;
    applyStimulus(32, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_divzero", 64'(div_zero), 64'd0);
    checkOutput("reset8_busy", 64'(busy8), 64'd0);
    reset = 1'b0;
    idle(1);

    doOp(32, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, "smul_7x-3");
    idle(1);
    doOp(32, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umul_max");
    idle(1);
    doOp(32, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "smul_m1");
    idle(1);
    doOp(32, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "sdiv_-7/2");
    idle(1);
    doOp(32, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, "udiv_100/7");
    idle(1);
    doOp(32, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "sdiv_min/-1");
    idle(1);

    // Leave hi/lo = 1234/5678, then divide by zero.
    doOp(32, 1'b1, 1'b0, 32'h5678_1234, 32'h0001_0000, 1'b0, 1'b0, "udiv_setup");
    idle(1);
    applyStimulus(32, 1'b0, 1'b1, 1'($urandom), $urandom, 32'h0);
    @(posedge clk); #1;
    applyStimulus(32, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    checkOutput("dz_done", 64'(done), 64'd1);
    checkOutput("dz_flag", 64'(div_zero), 64'd1);
    checkOutput("dz_busy", 64'(busy), 64'd0);
    checkOutput("dz_hi", 64'(hi), 64'h1234);
    checkOutput("dz_lo", 64'(lo), 64'h5678);
    idle(1);
    checkOutput("dz_done_pulse", 64'(done), 64'd0);
    checkOutput("dz_flag_pulse", 64'(div_zero), 64'd0);
    checkOutput("dz_busy_after", 64'(busy), 64'd0);

    doOp(32, 1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1, "mul_inject_div");
    idle(1);
    doOp(32, 1'b0, 1'b1, $urandom, $urandom | 32'h1, 1'b1, 1'b0, "both_starts");
    idle(2);
    doOp(32, 1'b1, 1'b1, $urandom, 32'hFFFF_FF00, 1'b0, 1'b0, "b2b_first");
    doOp(32, 1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0, "b2b_second");
    doOp(32, 1'b1, 1'b0, $urandom, 32'd13, 1'b0, 1'b0, "b2b_third");
    idle(1);

    // Reset ten cycles into a divide: outputs clear and no done follows.
    applyStimulus(32, 1'b0, 1'b1, 1'b1, $urandom, 32'd5);
    idle(1);
    applyStimulus(32, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(9);
    reset = 1'b1;
    idle(1);
    checkOutput("rst_mid_hi", 64'(hi), 64'd0);
    checkOutput("rst_mid_lo", 64'(lo), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_done", 64'(done), 64'd0);
    checkOutput("rst_mid_divzero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (waited = 0; waited < 40; waited++) begin
      idle(1);
      if (done || busy) saw_done = 1'b1;
    end
    checkOutput("rst_mid_no_done", 64'(saw_done), 64'd0);

    doOp(8, 1'b0, 1'b1, 32'h80, 32'h80, 1'b0, 1'b0, "w8_smul_min");
    idle(1);
    doOp(8, 1'b1, 1'b1, 32'h80, 32'hFF, 1'b0, 1'b0, "w8_sdiv_min/-1");
    idle(1);
    randomOps(8, 15);
    randomOps(32, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
